// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the data-memory port arbiter.
// Holds the FSM encoding and word-addressing helpers.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] beat_off(
    input logic [31:0] beat
  );
    return beat * WORD_BYTES;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side bundle.
// slave = arbiter view, master = requesters plus RAM.
interface mem_port_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_burst;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic [31:0]        mem_addr;
  logic               mem_we;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_burst,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_burst,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority picker.
// First set req bit at or above ptr, wrapping, wins.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam int SW = IW + 1;

  logic [SW-1:0] s;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + SW'(k);
      if (s >= SW'(N)) s = s - SW'(N);
      j = s[IW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the data-memory port.
// Locks to one requester for a VEC_LEN-word burst.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int VEC_LEN = 4,
  parameter int RD_LAT  = 1
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(VEC_LEN);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(VEC_LEN - 1);

  if (RD_LAT != 1) begin : g_lat_chk
    $error("mem_port_arbiter: RD_LAT must be 1");
  end

  arb_state_t state, state_nx;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rd_owner;
  logic [CW-1:0]   beat_cnt;
  logic [31:0]     base;
  logic            burst_we;
  logic            rd_pend;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            beat;
  logic            beat_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [31:0]     o_wdata;

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] x
  );
    return (x == LAST_REQ) ? '0 : x + 1'b1;
  endfunction

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign w_addr  = bus.req_addr[32*pick_idx +: 32];
  assign w_wdata = bus.req_wdata[32*pick_idx +: 32];
  assign o_wdata = bus.req_wdata[32*owner +: 32];

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    beat          = 1'b0;
    beat_we       = 1'b0;
    bus.req_ready = '0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any && !reset) begin
          beat          = 1'b1;
          beat_we       = bus.req_we[pick_idx];
          bus.req_ready = pick_gnt;
          bus.mem_addr  = w_addr;
          bus.mem_we    = beat_we;
          bus.mem_wdata = w_wdata;
          if (bus.req_burst[pick_idx])
            state_nx = ARB_BURST;
        end
      end
      ARB_BURST: begin
        bus.mem_addr = base + beat_off(32'(beat_cnt));
        if (bus.req_valid[owner] && !reset) begin
          beat                 = 1'b1;
          beat_we              = burst_we;
          bus.req_ready[owner] = 1'b1;
          bus.mem_we           = burst_we;
          bus.mem_wdata        = o_wdata;
          if (beat_cnt == LAST_BEAT)
            state_nx = ARB_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      owner    <= '0;
      rd_owner <= '0;
      beat_cnt <= '0;
      base     <= '0;
      burst_we <= 1'b0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= beat && !beat_we;
      if (beat)
        rd_owner <= (state == ARB_IDLE) ? pick_idx : owner;
      if (state == ARB_IDLE) begin
        if (beat) begin
          if (bus.req_burst[pick_idx]) begin
            base     <= w_addr;
            owner    <= pick_idx;
            burst_we <= beat_we;
            beat_cnt <= CW'(1);
          end else begin
            rr_ptr <= nxt(pick_idx);
          end
        end
      end else if (beat) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          rr_ptr   <= nxt(owner);
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Read data lands one cycle after the beat; reset kills it.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (rd_pend && !reset) begin
      bus.rsp_valid[rd_owner] = 1'b1;
      bus.rsp_rdata           = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int VL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(N)) bus();

  mem_port_arbiter #(
    .NREQ    (N),
    .VEC_LEN (VL),
    .RD_LAT  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  logic [31:0] ram [256];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[9:2]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int i, input bit v, input bit we,
                     input bit b, input logic [31:0] a,
                     input logic [31:0] d);
    bus.req_valid[i] = v;
    bus.req_we[i]    = we;
    bus.req_burst[i] = b;
    bus.req_addr[32*i +: 32]  = a;
    bus.req_wdata[32*i +: 32] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drv(i, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [1:0] rdy,
                     input logic we, input bit ca,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic [1:0] rsp,
                     input logic [31:0] rd);
    @(negedge clk);
    chk({nm, ".rdy"}, 32'(bus.req_ready), 32'(rdy));
    chk({nm, ".we"}, 32'(bus.mem_we), 32'(we));
    if (ca) chk({nm, ".addr"}, bus.mem_addr, addr);
    if (we) chk({nm, ".wdata"}, bus.mem_wdata, wd);
    chk({nm, ".rsp"}, 32'(bus.rsp_valid), 32'(rsp));
    if (rsp != 0) chk({nm, ".rdata"}, bus.rsp_rdata, rd);
    step();
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rdy;
    logic [31:0] addr;
    logic [1:0]  rsp;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[8];

  task automatic run_random(input int ncyc);
    bit          t_act[N];
    bit          t_we[N];
    bit          t_b[N];
    logic [31:0] t_addr[N];
    int          t_left[N];
    logic [31:0] shadow[256];
    logic [31:0] wd[N];
    bit          v[N];
    int          m_owner, m_done, m_rr, j, bi, pown;
    logic [31:0] m_base, e_addr, e_wd, pdata;
    logic [1:0]  e_rdy, e_rsp;
    bit          m_dir, e_we, pv, npv;
    m_owner = -1;
    m_done  = 0;
    m_rr    = 0;
    m_base  = '0;
    m_dir   = 0;
    pv      = 0;
    pown    = 0;
    pdata   = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    for (int i = 0; i < N; i++) begin
      t_act[i] = 0; t_we[i] = 0; t_b[i] = 0;
      t_addr[i] = '0; t_left[i] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!t_act[i] && $urandom_range(0, 2) != 0) begin
          t_act[i]  = 1;
          t_we[i]   = 1'($urandom_range(0, 1));
          t_b[i]    = 1'($urandom_range(0, 1));
          t_addr[i] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          t_left[i] = t_b[i] ? VL : 1;
        end
        v[i]  = t_act[i] && ($urandom_range(0, 3) != 0);
        wd[i] = $urandom;
        drv(i, v[i], t_we[i], t_b[i], t_addr[i], wd[i]);
      end
      bi = -1;
      e_addr = '0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (bi < 0 && v[j]) bi = j;
        end
        if (bi >= 0) e_addr = t_addr[bi];
      end else begin
        e_addr = m_base + 32'(4 * m_done);
        if (v[m_owner]) bi = m_owner;
      end
      e_rdy = '0;
      e_we  = 0;
      e_wd  = '0;
      if (bi >= 0) begin
        e_rdy = 2'(1 << bi);
        e_we  = (m_owner < 0) ? t_we[bi] : m_dir;
        e_wd  = wd[bi];
      end
      e_rsp = pv ? 2'(1 << pown) : 2'b00;
      cyc($sformatf("rnd%0d", c), e_rdy, e_we, 1'b1, e_addr,
          e_wd, e_rsp, pdata);
      npv = 0;
      if (bi >= 0) begin
        if (e_we) begin
          shadow[e_addr[9:2]] = e_wd;
        end else begin
          npv   = 1;
          pown  = bi;
          pdata = shadow[e_addr[9:2]];
        end
        t_left[bi]--;
        if (t_left[bi] == 0) t_act[bi] = 0;
        if (m_owner < 0) begin
          if (t_b[bi]) begin
            m_owner = bi;
            m_base  = e_addr;
            m_dir   = t_we[bi];
            m_done  = 1;
          end else begin
            m_rr = (bi + 1) % N;
          end
        end else begin
          m_done++;
          if (m_done == VL) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end
      pv = npv;
    end
    idle_all();
    step();
  endtask

  logic [31:0] wa[4];
  logic [31:0] wc[4];
  int          r;

  initial begin
    tbl[0] = '{2'b11, 2'b01, 32'h100, 2'b00, 32'h0};
    tbl[1] = '{2'b11, 2'b10, 32'h200, 2'b01, init_word(32'h40)};
    tbl[2] = '{2'b11, 2'b01, 32'h100, 2'b10, init_word(32'h80)};
    tbl[3] = '{2'b10, 2'b10, 32'h200, 2'b01, init_word(32'h40)};
    tbl[4] = '{2'b10, 2'b10, 32'h200, 2'b10, init_word(32'h80)};
    tbl[5] = '{2'b00, 2'b00, 32'h000, 2'b10, init_word(32'h80)};
    tbl[6] = '{2'b01, 2'b01, 32'h100, 2'b00, 32'h0};
    tbl[7] = '{2'b11, 2'b10, 32'h200, 2'b01, init_word(32'h40)};
    wa = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    wc = '{32'hE000_0000, 32'hE111_1111, 32'hE222_2222, 32'hE333_3333};

    // Reset with both requesters asserting.
    reset = 1'b1;
    idle_all();
    drv(0, 1, 1, 0, 32'h10, 32'h1);
    drv(1, 1, 1, 1, 32'h20, 32'h2);
    step();
    step();
    cyc("reset", 2'b00, 1'b0, 1'b0, 0, 0, 2'b00, 0);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      drv(0, tbl[k].v[0], 0, 0, 32'h100, 0);
      drv(1, tbl[k].v[1], 0, 0, 32'h200, 0);
      cyc($sformatf("vec%0d", k), tbl[k].rdy, 1'b0, 1'b1,
          tbl[k].addr, 0, tbl[k].rsp, tbl[k].rd);
    end

    for (int k = 0; k < 8; k++) begin
      drv(0, 1, 0, 0, 32'h10, 0);
      drv(1, 1, 0, 0, 32'h20, 0);
      r = (k == 0) ? 1 : (k - 1) % 2;
      cyc($sformatf("alt%0d", k), 2'(1 << (k % 2)), 1'b0, 1'b1,
          (k % 2) ? 32'h20 : 32'h10, 0, 2'(1 << r),
          (k == 0) ? init_word(32'h80)
                   : init_word(r == 0 ? 4 : 8));
    end
    idle_all();
    cyc("alt_drain", 2'b00, 0, 1, 0, 0, 2'b10, init_word(8));

    // Burst write from req0 holds off req1.
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, 1, 1, (k == 0) ? 32'h40 : 32'hDEAD_0000, wa[k]);
      if (k > 0) drv(1, 1, 0, 0, 32'h300, 0);
      cyc($sformatf("bw%0d", k), 2'b01, 1'b1, 1'b1,
          32'h40 + 32'(4 * k), wa[k], 2'b00, 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    cyc("bw_req1", 2'b10, 0, 1, 32'h300, 0, 2'b00, 0);
    idle_all();
    cyc("bw_rsp1", 2'b00, 0, 1, 0, 0, 2'b10, init_word(32'hC0));
    drv(0, 1, 0, 0, 32'h48, 0);
    cyc("bw_rdback", 2'b01, 0, 1, 32'h48, 0, 2'b00, 0);
    idle_all();
    cyc("bw_rdback_rsp", 2'b00, 0, 1, 0, 0, 2'b01, wa[2]);

    // Burst read wrapping past the top of the address space.
    for (int k = 0; k < 4; k++) begin
      drv(1, 1, 0, 1, (k == 0) ? 32'hFFFF_FFF8 : 32'h0, 0);
      cyc($sformatf("br%0d", k), 2'b10, 0, 1,
          32'hFFFF_FFF8 + 32'(4 * k), 0,
          (k == 0) ? 2'b00 : 2'b10,
          init_word((32'hFE + k - 1) % 256));
    end
    idle_all();
    cyc("br_last", 2'b00, 0, 1, 0, 0, 2'b10, init_word(1));

    // Owner stalls two cycles mid-burst; req1 must not sneak in.
    drv(0, 1, 1, 1, 32'h80, wc[0]);
    cyc("st0", 2'b01, 1, 1, 32'h80, wc[0], 2'b00, 0);
    drv(0, 1, 1, 1, 32'h0, wc[1]);
    cyc("st1", 2'b01, 1, 1, 32'h84, wc[1], 2'b00, 0);
    drv(0, 0, 1, 1, 32'h0, 32'hBAD0_BAD0);
    drv(1, 1, 0, 0, 32'h3F0, 0);
    cyc("st_gap0", 2'b00, 0, 1, 32'h88, 0, 2'b00, 0);
    cyc("st_gap1", 2'b00, 0, 1, 32'h88, 0, 2'b00, 0);
    drv(0, 1, 1, 1, 32'h0, wc[2]);
    cyc("st2", 2'b01, 1, 1, 32'h88, wc[2], 2'b00, 0);
    drv(0, 1, 1, 1, 32'h0, wc[3]);
    cyc("st3", 2'b01, 1, 1, 32'h8C, wc[3], 2'b00, 0);
    drv(0, 0, 0, 0, 0, 0);
    cyc("st_req1", 2'b10, 0, 1, 32'h3F0, 0, 2'b00, 0);
    idle_all();
    cyc("st_rsp1", 2'b00, 0, 1, 0, 0, 2'b10, init_word(32'hFC));

    // Reset lands on beat 2 of a burst read.
    drv(0, 1, 0, 1, 32'h100, 0);
    cyc("rb0", 2'b01, 0, 1, 32'h100, 0, 2'b00, 0);
    cyc("rb1", 2'b01, 0, 1, 32'h104, 0, 2'b01, init_word(32'h40));
    reset = 1'b1;
    cyc("rb_reset", 2'b00, 0, 0, 0, 0, 2'b00, 0);
    reset = 1'b0;
    drv(0, 1, 0, 0, 32'h104, 0);
    cyc("rb_fresh", 2'b01, 0, 1, 32'h104, 0, 2'b00, 0);
    idle_all();
    cyc("rb_fresh_rsp", 2'b00, 0, 1, 0, 0, 2'b01, init_word(32'h41));

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    run_random(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit data-memory port between NREQ requesters, e.g. the core load/store path and a host/DMA loader.
- Accepts single-word accesses and VEC_LEN-word vector bursts.
- Grants round-robin and locks the port to one owner for a whole burst.
- Sits between the requesters and the synchronous data RAM (1-cycle read latency); returns read data to the owner with a valid pulse.

Parameters:
- NREQ, 2, number of requesters.
- VEC_LEN, 4, words per burst (power of two, ≥2).
- RD_LAT, 1, memory read latency in cycles (fixed; only 1 supported).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i presents a beat.
- req_we  in  NREQ  1 = write, 0 = read; held for the whole burst.
- req_burst  in  NREQ  1 = VEC_LEN-word burst, 0 = single word.
- req_addr  in  NREQ*32  byte address, slice i = [32*i +:32]; sampled on the first beat only.
- req_wdata  in  NREQ*32  write data for the current beat.
- req_ready  out  NREQ  beat accepted this cycle (combinational).
- rsp_valid  out  NREQ  read data for requester i on rsp_rdata.
- rsp_rdata  out  32  shared read-return data.
- mem_addr  out  32  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid RD_LAT cycles after the address.

Behaviour:
- Reset values (next edge with reset=1):
  - state=IDLE, rr_ptr=0, beat_cnt=0, owner=0, rd_pend=0.
  - rsp_valid=0, rsp_rdata=0.
  - While reset=1: mem_we=0 and req_ready=0 combinationally.
- Reset mid-burst abandons the burst. Any read response still in flight is suppressed, not delivered.
- States: IDLE, BURST.
- IDLE arbitration:
  - Winner is the first set req_valid bit scanning from rr_ptr upward, with wrap-around.
  - Winner's req_ready=1 in the same cycle.
  - mem_addr=req_addr[w], mem_we=req_we[w], mem_wdata=req_wdata[w].
  - With no requests: mem_we=0, mem_addr=0, mem_wdata=0.
- Single access (req_burst=0): complete in one beat, stay in IDLE, rr_ptr <= (w+1) mod NREQ.
- Burst access (req_burst=1), first beat:
  - Latch base=req_addr[w], owner=w, burst direction=req_we[w].
  - Set beat_cnt=1 and go to BURST.
- BURST state:
  - Only the owner is served. All other req_ready=0.
  - mem_addr = base + {beat_cnt,2'b00}, mod 2^32 (wraps).
- Beat handshake in BURST:
  - A beat occurs only when req_valid[owner]=1. Then req_ready[owner]=1, the memory is driven, and beat_cnt increments.
  - When req_valid[owner]=0, no beat occurs: mem_we=0, no advance, grant stays locked.
- Burst end: on the beat with beat_cnt==VEC_LEN-1, go to IDLE, set beat_cnt=0, rr_ptr <= (owner+1) mod NREQ.
- Burst length is exactly VEC_LEN beats. The controller never issues a new request inside a burst.
- Read return:
  - Every accepted read beat registers rd_pend=1 and rd_owner.
  - Next cycle: rsp_valid[rd_owner]=1 and rsp_rdata=mem_rdata.
  - At most one rsp_valid bit is set per cycle.
  - Responses arrive in beat order; back-to-back beats produce back-to-back responses.
- Writes produce no response.
- Simultaneous events:
  - A new grant in IDLE and a response for the previous owner may coincide; both proceed.
  - Requests arriving during BURST wait; req_ready stays 0.
- Address bits [1:0] pass through unmodified. Alignment is the requester's responsibility.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum arb_state {ARB_IDLE, ARB_BURST}.
  - Localparam WORD_BYTES=4.
- Sub-module rr_picker (NREQ-wide round-robin priority picker: req, ptr -> one-hot grant + index). Purely combinational, reusable by other arbiters.

Test Plan:
- Reset, then req_valid=2'b11, both single reads, addr0=0x100, addr1=0x200 -> cycle 0 grants req0 (mem_addr=0x100); cycle 1 grants req1 (mem_addr=0x200); rsp_valid=01 then 10 with matching mem_rdata.
- Req0 burst write at base 0x40, wdata beats A,B,C,D; req1 single read asserted from cycle 1 -> mem_addr 0x40,0x44,0x48,0x4C with we=1, data A–D; req_ready[1]=0 until cycle 4, then req1 granted.
- Req1 burst read at base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap); four consecutive rsp_valid[1] pulses, each one cycle after its address.
- Owner drops req_valid for 2 cycles after beat 1 of a burst -> mem_we=0, beat_cnt holds, other requester is not granted; the burst resumes at base+8.
- Assert reset during beat 2 of a burst read -> next cycle state=IDLE, rsp_valid=0 (pending response dropped); a fresh req0 single read is granted right after reset deasserts.
- Continuous req_valid=11, all singles, for 8 cycles -> grants strictly alternate 0,1,0,1,…; no requester starves.
